// File: rtl/cpu_pkg.sv
// Shared types and encodings for the data-processing instruction sequencer.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_LOAD_A,
      S_LOAD_B,
      S_EXEC,
      S_WB
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_ORR,
      ALU_EOR,
      ALU_MOV,
      ALU_MVN
   } alu_op_t;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_MVN = 4'hF;

   localparam logic [3:0] EQ = 4'h0;
   localparam logic [3:0] NE = 4'h1;
   localparam logic [3:0] CS = 4'h2;
   localparam logic [3:0] CC = 4'h3;
   localparam logic [3:0] MI = 4'h4;
   localparam logic [3:0] PL = 4'h5;
   localparam logic [3:0] VS = 4'h6;
   localparam logic [3:0] VC = 4'h7;
   localparam logic [3:0] HI = 4'h8;
   localparam logic [3:0] LS = 4'h9;
   localparam logic [3:0] GE = 4'hA;
   localparam logic [3:0] LT = 4'hB;
   localparam logic [3:0] GT = 4'hC;
   localparam logic [3:0] LE = 4'hD;
   localparam logic [3:0] AL = 4'hE;
   localparam logic [3:0] NV = 4'hF;

   function automatic logic op_supported(input logic [3:0] op);
      case (op)
         OP_AND, OP_EOR, OP_SUB, OP_ADD,
         OP_CMP, OP_ORR, OP_MOV, OP_MVN: op_supported = 1'b1;
         default:                        op_supported = 1'b0;
      endcase
   endfunction

   // CMP is a flag-only subtract.
   function automatic alu_op_t op_to_alu(input logic [3:0] op);
      case (op)
         OP_AND:  op_to_alu = ALU_AND;
         OP_EOR:  op_to_alu = ALU_EOR;
         OP_SUB:  op_to_alu = ALU_SUB;
         OP_ADD:  op_to_alu = ALU_ADD;
         OP_CMP:  op_to_alu = ALU_SUB;
         OP_ORR:  op_to_alu = ALU_ORR;
         OP_MOV:  op_to_alu = ALU_MOV;
         OP_MVN:  op_to_alu = ALU_MVN;
         default: op_to_alu = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction handshake: an instruction is accepted on a rising edge where
// waiting and instr_valid are both high; instr is only sampled on that edge.
interface instr_sequencer_if #(
   parameter int DW = 32
);
   logic [DW-1:0] instr;
   logic          instr_valid;
   logic          waiting;

   modport master (output instr, output instr_valid, input  waiting);
   modport slave  (input  instr, input  instr_valid, output waiting);
endinterface

// File: rtl/cond_eval.sv
// ARM condition-code evaluation against {N,Z,C,V}; NV never passes.
module cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_nzcv,
   output logic       o_pass
);

   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = i_nzcv;

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         EQ: o_pass = w_z;
         NE: o_pass = !w_z;
         CS: o_pass = w_c;
         CC: o_pass = !w_c;
         MI: o_pass = w_n;
         PL: o_pass = !w_n;
         VS: o_pass = w_v;
         VC: o_pass = !w_v;
         HI: o_pass = w_c && !w_z;
         LS: o_pass = !w_c || w_z;
         GE: o_pass = (w_n == w_v);
         LT: o_pass = (w_n != w_v);
         GT: o_pass = !w_z && (w_n == w_v);
         LE: o_pass = w_z || (w_n != w_v);
         AL: o_pass = 1'b1;
         NV: o_pass = 1'b0;
         default: o_pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for ARM data-processing instructions: one datapath
// stage per cycle, Moore outputs decoded from state and the captured word.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int REG_AW = 4,
   parameter int DW     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_sequencer_if.slave  ibus,
   input  logic [3:0]        nzcv,
   output logic [REG_AW-1:0] rd_addr,
   output logic              en_A,
   output logic              en_B,
   output logic              sel_imm,
   output logic [DW-1:0]     imm32,
   output logic [2:0]        alu_op,
   output logic              en_C,
   output logic              en_status,
   output logic              w_en,
   output logic [REG_AW-1:0] w_addr,
   output logic              illegal,
   output state_t            o_dbg_state
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [DW-1:0] r_instr;
   logic          w_waiting;
   logic          w_accept;
   logic          w_pass;

   logic [3:0]    w_cond;
   logic          w_i;
   logic [3:0]    w_op;
   logic          w_s;
   logic [3:0]    w_rn;
   logic [3:0]    w_rd;
   logic [3:0]    w_rm;
   logic          w_is_cmp;
   logic [31:0]   w_imm_ext;
   logic [4:0]    w_rot;
   logic          w_unused;

   assign w_cond   = r_instr[31:28];
   assign w_i      = r_instr[25];
   assign w_op     = r_instr[24:21];
   assign w_s      = r_instr[20];
   assign w_rn     = r_instr[19:16];
   assign w_rd     = r_instr[15:12];
   assign w_rm     = r_instr[3:0];
   assign w_is_cmp = (w_op == OP_CMP);
   assign w_unused = ^r_instr[27:26];

   // Rotate right by 2*rot; a left shift by 32 yields zero, covering rot=0.
   assign w_imm_ext = {24'd0, r_instr[7:0]};
   assign w_rot     = {r_instr[11:8], 1'b0};
   assign imm32     = (w_imm_ext >> w_rot) | (w_imm_ext << (6'd32 - {1'b0, w_rot}));

   assign w_accept     = w_waiting && ibus.instr_valid;
   assign ibus.waiting = w_waiting;
   assign o_dbg_state  = r_state;

   cond_eval u_cond_eval (
      .i_cond (w_cond),
      .i_nzcv (nzcv),
      .o_pass (w_pass)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_instr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_instr <= ibus.instr;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_waiting   = 1'b0;
      rd_addr     = '0;
      en_A        = 1'b0;
      en_B        = 1'b0;
      sel_imm     = 1'b0;
      alu_op      = ALU_ADD;
      en_C        = 1'b0;
      en_status   = 1'b0;
      w_en        = 1'b0;
      w_addr      = '0;
      illegal     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_waiting = 1'b1;
            if (ibus.instr_valid) begin
               w_state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!w_pass) begin
               w_state_nxt = S_IDLE;
            end else if (!op_supported(w_op)) begin
               illegal     = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_LOAD_A;
            end
         end
         S_LOAD_A: begin
            rd_addr     = REG_AW'(w_rn);
            en_A        = 1'b1;
            w_state_nxt = S_LOAD_B;
         end
         S_LOAD_B: begin
            rd_addr     = REG_AW'(w_rm);
            en_B        = 1'b1;
            sel_imm     = w_i;
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            alu_op      = op_to_alu(w_op);
            en_C        = 1'b1;
            en_status   = w_s || w_is_cmp;
            w_state_nxt = S_WB;
         end
         S_WB: begin
            if (!w_is_cmp) begin
               w_en   = 1'b1;
               w_addr = REG_AW'(w_rd);
            end
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: directed cases then random instructions, each checked
// cycle by cycle against an expected-output timeline built from the ISA rules.
module tb_instr_sequencer;
   import cpu_pkg::*;

   localparam int VW = 19;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  nzcv;
   logic [3:0]  rd_addr, w_addr;
   logic        en_A, en_B, sel_imm, en_C, en_status, w_en, illegal;
   logic [31:0] imm32;
   logic [2:0]  alu_op;
   state_t      dbg_state;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [VW-1:0] exp_q[$];
   logic [31:0] m_imm;

   always #5 clk = ~clk;

   instr_sequencer_if #(.DW(32)) ibus ();

   instr_sequencer #(.REG_AW(4), .DW(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ibus        (ibus),
      .nzcv        (nzcv),
      .rd_addr     (rd_addr),
      .en_A        (en_A),
      .en_B        (en_B),
      .sel_imm     (sel_imm),
      .imm32       (imm32),
      .alu_op      (alu_op),
      .en_C        (en_C),
      .en_status   (en_status),
      .w_en        (w_en),
      .w_addr      (w_addr),
      .illegal     (illegal),
      .o_dbg_state (dbg_state)
   );

   wire [VW-1:0] obs_vec = {ibus.waiting, rd_addr, en_A, en_B, sel_imm, alu_op,
                            en_C, en_status, w_en, w_addr, illegal};

   function automatic logic [VW-1:0] pack(input logic wt, input logic [3:0] rd,
      input logic ea, input logic eb, input logic si, input logic [2:0] alu,
      input logic ec, input logic es, input logic we, input logic [3:0] wa,
      input logic ill);
      return {wt, rd, ea, eb, si, alu, ec, es, we, wa, ill};
   endfunction

   // Condition check in the ISA's pair form: even code tests, odd code inverts.
   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (cond == 4'hF) return 1'b0;
      return cond[0] ? !base : base;
   endfunction

   function automatic logic [31:0] model_imm(input logic [31:0] w);
      logic [31:0] x;
      int          rot;
      x   = {24'd0, w[7:0]};
      rot = 2 * int'(w[11:8]);
      for (int i = 0; i < rot; i++) x = {x[0], x[31:1]};
      return x;
   endfunction

   // Returns {supported, alu code}.
   function automatic logic [3:0] model_alu(input logic [3:0] op);
      case (op)
         4'h0: return {1'b1, ALU_AND};
         4'h1: return {1'b1, ALU_EOR};
         4'h2: return {1'b1, ALU_SUB};
         4'h4: return {1'b1, ALU_ADD};
         4'hA: return {1'b1, ALU_SUB};
         4'hC: return {1'b1, ALU_ORR};
         4'hD: return {1'b1, ALU_MOV};
         4'hF: return {1'b1, ALU_MVN};
         default: return 4'b0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_idle"}, 32'(obs_vec), 32'(pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      check({tag, "_imm"}, imm32, m_imm);
   endtask

   task automatic check_next(input string tag);
      logic [VW-1:0] e;
      e = exp_q.pop_front();
      check({tag, "_vec"}, 32'(obs_vec), 32'(e));
      check({tag, "_imm"}, imm32, m_imm);
   endtask

   // Checks the remaining timeline while driving noise that must be ignored.
   task automatic busy_cycles(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         check_next(tag);
         ibus.instr       = $urandom;
         ibus.instr_valid = 1'($urandom_range(0, 1));
         step();
      end
   endtask

   task automatic start(input logic [31:0] w, input logic [3:0] f, input string tag);
      logic [3:0] alu;
      logic       is_cmp;
      check_idle(tag);
      ibus.instr       = w;
      ibus.instr_valid = 1'b1;
      nzcv             = f;
      alu              = model_alu(w[24:21]);
      is_cmp           = (w[24:21] == 4'hA);
      exp_q.delete();
      if (!cond_ok(w[31:28], f)) begin
         exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end else if (!alu[3]) begin
         exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end else begin
         exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(pack(0, w[19:16], 1, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(pack(0, w[3:0], 0, 1, w[25], 0, 0, 0, 0, 0, 0));
         exp_q.push_back(pack(0, 0, 0, 0, 0, alu[2:0], 1, w[20] | is_cmp, 0, 0, 0));
         exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, !is_cmp, is_cmp ? 4'd0 : w[15:12], 0));
      end
      step();
      m_imm = model_imm(w);
   endtask

   task automatic run(input logic [31:0] w, input logic [3:0] f, input string tag);
      start(w, f, tag);
      busy_cycles(exp_q.size(), tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      rst_n            = 1'b0;
      ibus.instr       = 32'h0;
      ibus.instr_valid = 1'b0;
      nzcv             = 4'h0;
      m_imm            = 32'h0;
      step();
      step();
      rst_n = 1'b1;
      check_idle("reset");

      // Reset while in LOAD_B, then a fresh accept must behave normally.
      start(32'hE0910002, 4'h0, "rst_mid");
      busy_cycles(2, "rst_mid");
      check_next("rst_mid_loadb");
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      exp_q.delete();
      m_imm = 32'h0;

      run(32'hE3A03005, 4'h0, "mov_r3_5");
      run(32'hE0910002, 4'h0, "adds");
      run(32'hE35404FF, 4'h0, "cmp_rot");
      run(32'h10810002, 4'h4, "addne_skip");
      run(32'h00810002, 4'h4, "addeq_exec");
      run(32'hE1110002, 4'h0, "tst_illegal");
      run(32'hF0810002, 4'hF, "nv_never");
      run(32'hE1E0500F, 4'h9, "mvn");

      for (int t = 0; t < 40; t++) begin
         w = $urandom;
         if ($urandom_range(0, 1) == 1) w[31:28] = 4'hE;
         run(w, 4'($urandom_range(0, 15)), $sformatf("rand%0d", t));
      end

      ibus.instr_valid = 1'b0;
      check_idle("final");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM that sequences the CPU datapath for ARM data-processing instructions. It sits inside `cpu`, between the instruction input and the datapath/register file.
- Per instruction it captures the instruction word and evaluates the condition field against NZCV. It then drives the register-file read, operand latch, ALU, flag-update and write-back strobes one stage per cycle.
- It raises `waiting` when ready for the next instruction.

Parameters:
- REG_AW, 4, register-file address width (16 registers).
- DW, 32, datapath and instruction width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- instr  in  DW  instruction word, sampled only on accept
- instr_valid  in  1  instruction present
- nzcv  in  4  current status flags {N,Z,C,V} from datapath
- waiting  out  1  high in IDLE; accept = waiting & instr_valid
- rd_addr  out  REG_AW  register-file read address
- en_A  out  1  latch register read into operand A
- en_B  out  1  latch register read into operand B
- sel_imm  out  1  operand B sourced from imm32 instead of register
- imm32  out  DW  decoded immediate
- alu_op  out  3  ALU operation code
- en_C  out  1  latch ALU result
- en_status  out  1  latch ALU flags into status register
- w_en  out  1  register-file write enable
- w_addr  out  REG_AW  write-back register address
- illegal  out  1  one-cycle pulse: unsupported opcode

Behaviour:
- Scope: data-processing only. I = instr[25], opcode = instr[24:21], S = instr[20], Rn = [19:16], Rd = [15:12], Rm = [3:0], cond = [31:28].
- Supported opcodes: AND, EOR, SUB, ADD, ORR, MOV, MVN, CMP. The register shift field [11:4] is ignored (treated as LSL #0).
- imm32 = ZeroExt(instr[7:0]) rotated right by 2*instr[11:8], computed from the captured word.
- States: IDLE, DECODE, LOAD_A, LOAD_B, EXEC, WB. All outputs are Moore-decoded from state and the captured instruction register.
- Reset (rst_n=0 at a clock edge, including mid-instruction):
  - state goes to IDLE and the captured instruction clears to 0.
  - Next cycle: waiting=1; all strobes (en_A/en_B/en_C/en_status/w_en/illegal/sel_imm) = 0; rd_addr = 0, w_addr = 0, alu_op = 0, imm32 = 0.
- IDLE: waiting=1. On accept, capture instr and go to DECODE. Without instr_valid, stay in IDLE.
- DECODE: evaluate cond against nzcv.
  - cond false -> IDLE. No strobes; 2-cycle occupancy.
  - Unsupported opcode -> illegal=1 for this cycle, then IDLE (NOP).
  - cond=1111 (NV) is treated as false.
  - Otherwise -> LOAD_A.
- LOAD_A: rd_addr=Rn, en_A=1. MOV/MVN still pass through this state (A unused) so latency is uniform. Next state LOAD_B.
- LOAD_B: rd_addr=Rm, en_B=1, sel_imm=I. Next state EXEC.
- EXEC: alu_op driven, en_C=1. en_status=1 if S=1 or opcode=CMP. Next state WB.
- WB: w_en=1 and w_addr=Rd, except for CMP (w_en=0). Next state IDLE.
- Executed-instruction latency: accept edge to WB = 5 cycles. waiting reasserts in the 6th cycle after accept.
- Flags sampled in DECODE reflect every prior instruction, because en_status completes before IDLE. No hazards exist.
- instr changes while busy are ignored.
- alu_op is 0 outside EXEC.

Decomposition:
- cpu_pkg holds:
  - state_t enum.
  - Opcode constants OP_AND..OP_CMP.
  - Condition constants EQ..AL, NV.
  - alu_op_t {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_MOV, ALU_MVN}.
- Sub-module cond_eval: combinational (cond, nzcv) -> pass. Instantiated once.

Test Plan:
- Reset mid-LOAD_B with rst_n=0 for one edge -> next cycle waiting=1, all strobes 0. A new accept is honoured normally.
- MOV R3,#5 (0xE3A03005) accepted -> 5 cycles later w_en=1, w_addr=3; sel_imm=1 and imm32=5 during LOAD_B; waiting=1 on cycle 6.
- ADDS R0,R1,R2 (0xE0910002) -> rd_addr 1 in LOAD_A, 2 in LOAD_B; in EXEC alu_op=ALU_ADD, en_C=1, en_status=1; w_en=1, w_addr=0 in WB.
- CMP R4,#0xFF000000 (imm8=0xFF, rot=4) -> imm32=0xFF000000, en_status=1, w_en never asserts.
- Condition gating, nzcv=0100 (Z=1): ADDNE (cond 0001) -> back in IDLE after 2 cycles with zero strobes; same instr with ADDEQ (cond 0000) -> full 6-cycle sequence.
- Unsupported opcode TST (opcode 1000) -> illegal=1 for exactly one cycle in DECODE, no register strobes, waiting=1 two cycles after accept.
